pixel_line_buffer: RTL
======================

PIXEL_LINE_BUFFER -- requirements
Module: pixel_line_buffer

Interface
REQ-001 Parameter LINE_PIX, default 640, maximum source pixels per line stored per bank.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_wr_valid  input  1  source pixel strobe; i_wr_data is valid this cycle.
REQ-005 i_wr_data  input  24  source pixel, {R[23:16], G[15:8], B[7:0]}.
REQ-006 i_wr_line_end  input  1  one-cycle pulse marking the end of a source line.
REQ-007 i_wr_frame_end  input  1  one-cycle pulse marking the end of a source frame.
REQ-008 i_x  input  12  display beam X from the timing generator.
REQ-009 i_y  input  12  display beam Y from the timing generator.
REQ-010 i_rd_en  input  1  display data-enable; pixel is requested this cycle.
REQ-011 o_r, o_g, o_b  output  8 each  pixel to the timing generator RGB inputs.
REQ-012 o_frame_end  output  1  one-cycle pulse to the timing generator's frame-end input.
REQ-013 o_overflow  output  1  sticky flag; a source pixel or line was dropped.
REQ-014 o_wr_bank  output  1  index of the bank currently being written.

Function
REQ-015 Storage SHALL be two banks, each LINE_PIX x 24 bits, with one write and one read port.
REQ-016 The write pointer wr_addr SHALL increment on each i_wr_valid; a pixel with wr_addr >= LINE_PIX SHALL be dropped and SHALL set o_overflow.
REQ-017 Each bank SHALL have a full flag; i_wr_line_end SHALL set full[o_wr_bank] and clear wr_addr to 0.
REQ-018 The write FSM SHALL have states FILL and HOLD; FILL->FILL with an o_wr_bank toggle on line end when full[~o_wr_bank]=0; FILL->HOLD on line end when full[~o_wr_bank]=1.
REQ-019 In HOLD, i_wr_valid pixels and i_wr_line_end SHALL be dropped and SHALL set o_overflow; HOLD->FILL with an o_wr_bank toggle in the cycle after full[~o_wr_bank] clears.
REQ-020 Read-side line change SHALL be detected as the registered i_y differing from the current i_y.
REQ-021 A release event SHALL clear full[rd_bank] and toggle rd_bank, where rd_bank is the bank not being written.
REQ-022 When a release and i_wr_line_end occur in the same cycle, the release SHALL be applied first, so FILL stays in FILL and toggles.
REQ-023 Read address SHALL be taken from i_x as defined in REQ-032 and REQ-033; o_r/o_g/o_b SHALL be registered with 1-cycle latency from i_x/i_y/i_rd_en.
REQ-024 Output SHALL be 0/0/0 when i_rd_en=0, when the read address is >= LINE_PIX, or when full[rd_bank]=0 (underflow).
REQ-025 o_frame_end SHALL equal i_wr_frame_end delayed by exactly 1 cycle.
REQ-026 i_wr_frame_end SHALL clear wr_addr to 0 and leave the full flags and the FSM state unchanged.
REQ-027 All counters SHALL be 12 bits; no arithmetic SHALL wrap inside the valid range.

Reset
REQ-028 On rst: o_r/o_g/o_b=0, o_frame_end=0, o_overflow=0, o_wr_bank=0, rd_bank=1, wr_addr=0, both full flags=0, FSM=FILL, registered i_y=0.
REQ-029 Reset asserted mid-line SHALL discard the partial line; the first line after reset is written to bank 0.
REQ-030 Only rst SHALL clear o_overflow.
REQ-031 Memory contents need no reset.

Configuration
REQ-032 With macro PIXEL_SCALE_2X_EN defined: read address SHALL be i_x>>1, and a release SHALL occur only on a line change where the previous registered i_y is odd, so each source line is shown twice.
REQ-033 Without PIXEL_SCALE_2X_EN: read address SHALL be i_x, and every line change SHALL be a release.

Verification
REQ-034 Reset, then i_rd_en=1, x=5 -> output 0/0/0 one cycle later (underflow); o_overflow=0.
REQ-035 Write 640 pixels with data=addr, then line end, then y 0->1 -> bank 0 full; with x=10, output {R,G,B}=0x00000A one cycle later; o_wr_bank=1.
REQ-036 Write 641 pixels in one line -> pixel 641 dropped; o_overflow=1 and stays 1 until rst.
REQ-037 Fill both banks with no read release -> FSM=HOLD and a third line is dropped; a release occurs -> FILL within 1 cycle, o_wr_bank toggles.
REQ-038 i_wr_frame_end pulse at cycle N -> o_frame_end high at cycle N+1 only; the next pixel is written at address 0.
REQ-039 With PIXEL_SCALE_2X_EN: x=20 and x=21 both return source pixel 10; y=0 and y=1 show the same line; the bank is released at y 1->2.

Source files
------------

// File: rtl/pixel_line_buffer_if.sv
// Signal bundle between the source/timing generator and pixel_line_buffer.
// The dbg_* signals expose internal state so external checkers can bind to it.
interface pixel_line_buffer_if;
  logic        i_wr_valid;
  logic [23:0] i_wr_data;
  logic        i_wr_line_end;
  logic        i_wr_frame_end;
  logic [11:0] i_x;
  logic [11:0] i_y;
  logic        i_rd_en;
  logic [7:0]  o_r;
  logic [7:0]  o_g;
  logic [7:0]  o_b;
  logic        o_frame_end;
  logic        o_overflow;
  logic        o_wr_bank;
  logic [0:0]  dbg_state;
  logic [1:0]  dbg_full;
  logic        dbg_rd_bank;

  // Write side is strobe-only: a pixel is accepted or dropped in the cycle
  // i_wr_valid is high; there is no back-pressure. Read data follows
  // i_x/i_y/i_rd_en by exactly one clock.
  modport slave (
    input  i_wr_valid, i_wr_data, i_wr_line_end, i_wr_frame_end,
    input  i_x, i_y, i_rd_en,
    output o_r, o_g, o_b, o_frame_end, o_overflow, o_wr_bank,
    output dbg_state, dbg_full, dbg_rd_bank
  );

  modport master (
    output i_wr_valid, i_wr_data, i_wr_line_end, i_wr_frame_end,
    output i_x, i_y, i_rd_en,
    input  o_r, o_g, o_b, o_frame_end, o_overflow, o_wr_bank,
    input  dbg_state, dbg_full, dbg_rd_bank
  );
endinterface

// File: rtl/pixel_line_buffer.sv
// Two-bank line buffer between a pixel source and a display timing generator.
// Optional macro PIXEL_SCALE_2X_EN: 2x horizontal/vertical pixel doubling.
module pixel_line_buffer #(
  parameter int LINE_PIX = 640
) (
  input  logic               clk,
  input  logic               rst,
  pixel_line_buffer_if.slave bus
);

  localparam int         AW       = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam logic [11:0] LINE_LIM = 12'(LINE_PIX);
  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [23:0] mem0 [LINE_PIX];
  logic [23:0] mem1 [LINE_PIX];

  logic [0:0]  state_q, state_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [1:0]  full_q, full_d, full_rel;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        overflow_q, overflow_d;
  logic [11:0] y_q;
  logic [23:0] rgb_q, rgb_d;
  logic        frame_end_q;

  logic        wr_en;
  logic        line_chg;
  logic        release_ev;
  logic [11:0] rd_addr;
  logic        rd_ok;
  logic [23:0] rd_word;

  assign line_chg = (y_q != bus.i_y);

`ifdef PIXEL_SCALE_2X_EN
  // Each source line is shown on an even/odd display line pair.
  assign rd_addr    = {1'b0, bus.i_x[11:1]};
  assign release_ev = line_chg & y_q[0];
`else
  assign rd_addr    = bus.i_x;
  assign release_ev = line_chg;
`endif

  always_comb begin
    full_rel = full_q;
    if (release_ev) full_rel[rd_bank_q] = 1'b0;

    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    full_d     = full_rel;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = release_ev ? ~rd_bank_q : rd_bank_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (bus.i_wr_valid) begin
          if (wr_addr_q < LINE_LIM) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + 12'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Release is folded in first, so a same-cycle release frees the other bank.
        if (bus.i_wr_line_end) begin
          full_d[wr_bank_q] = 1'b1;
          wr_addr_d         = 12'd0;
          if (full_rel[~wr_bank_q]) state_d   = ST_HOLD;
          else                      wr_bank_d = ~wr_bank_q;
        end
      end
      ST_HOLD: begin
        if (bus.i_wr_valid || bus.i_wr_line_end) overflow_d = 1'b1;
        if (!full_q[~wr_bank_q]) begin
          state_d   = ST_FILL;
          wr_bank_d = ~wr_bank_q;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (bus.i_wr_frame_end) wr_addr_d = 12'd0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) mem1[wr_addr_q[AW-1:0]] <= bus.i_wr_data;
      else           mem0[wr_addr_q[AW-1:0]] <= bus.i_wr_data;
    end
  end

  assign rd_word = rd_bank_q ? mem1[rd_addr[AW-1:0]] : mem0[rd_addr[AW-1:0]];
  assign rd_ok   = bus.i_rd_en && (rd_addr < LINE_LIM) && full_q[rd_bank_q];
  assign rgb_d   = rd_ok ? rd_word : 24'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_addr_q   <= 12'd0;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      overflow_q  <= 1'b0;
      y_q         <= 12'd0;
      rgb_q       <= 24'd0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      overflow_q  <= overflow_d;
      y_q         <= bus.i_y;
      rgb_q       <= rgb_d;
      frame_end_q <= bus.i_wr_frame_end;
    end
  end

  assign bus.o_r         = rgb_q[23:16];
  assign bus.o_g         = rgb_q[15:8];
  assign bus.o_b         = rgb_q[7:0];
  assign bus.o_frame_end = frame_end_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_wr_bank   = wr_bank_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_full    = full_q;
  assign bus.dbg_rd_bank = rd_bank_q;

endmodule
